// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the op and state encodings plus the operand classification helpers.
package md_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 5;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } md_state_e;

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide engine.
// The master issues operations; the slave (the engine) returns HI/LO and status.
interface mult_div_unit_if;
  import md_pkg::*;

  logic              start;
  md_op_e            op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div_by_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/md_sign_fix.sv
// Signed-magnitude conversion around the unsigned iterative core: operand
// magnitudes and sign flags on entry, negation of product/quotient/remainder on exit.
module md_sign_fix
  import md_pkg::*;
(
  input  md_op_e              i_op,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [DATA_W-1:0]   o_a_mag,
  output logic [DATA_W-1:0]   o_b_mag,
  output logic                o_neg_res,
  output logic                o_neg_rem,
  input  logic                i_is_div,
  input  logic                i_neg_res,
  input  logic                i_neg_rem,
  input  logic [2*DATA_W-1:0] i_acc,
  output logic [DATA_W-1:0]   o_hi,
  output logic [DATA_W-1:0]   o_lo
);

  logic                w_signed;
  logic [2*DATA_W-1:0] w_prod;

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_signed  = is_signed_op(i_op);
    o_a_mag   = (w_signed && i_a[DATA_W-1]) ? -i_a : i_a;
    o_b_mag   = (w_signed && i_b[DATA_W-1]) ? -i_b : i_b;
    o_neg_res = w_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
    o_neg_rem = w_signed & i_a[DATA_W-1];

    w_prod = i_neg_res ? -i_acc : i_acc;
    o_hi   = w_prod[2*DATA_W-1:DATA_W];
    o_lo   = w_prod[DATA_W-1:0];
    if (i_is_div) begin
      // Quotient sits in the low half, remainder in the high half.
      o_lo = i_neg_res ? -i_acc[DATA_W-1:0] : i_acc[DATA_W-1:0];
      o_hi = i_neg_rem ? -i_acc[2*DATA_W-1:DATA_W] : i_acc[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide engine: one shift-add or restoring
// shift-subtract step per cycle for 32 cycles, producing the HI/LO pair.
module mult_div_unit
  import md_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  md_state_e           r_state;
  logic [CNT_W-1:0]    r_cnt;
  md_op_e              r_op;
  logic [DATA_W-1:0]   r_opnd;
  logic [2*DATA_W-1:0] r_acc;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic [DATA_W-1:0]   r_a_raw;
  logic                r_b_zero;

  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic                w_neg_res;
  logic                w_neg_rem;
  logic [DATA_W-1:0]   w_hi;
  logic [DATA_W-1:0]   w_lo;
  logic                w_start_div;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_step;

  md_sign_fix u_sign_fix (
    .i_op      (bus.op),
    .i_a       (bus.operand_a),
    .i_b       (bus.operand_b),
    .o_a_mag   (w_a_mag),
    .o_b_mag   (w_b_mag),
    .o_neg_res (w_neg_res),
    .o_neg_rem (w_neg_rem),
    .i_is_div  (is_div_op(r_op)),
    .i_neg_res (r_neg_res),
    .i_neg_rem (r_neg_rem),
    .i_acc     (r_acc),
    .o_hi      (w_hi),
    .o_lo      (w_lo)
  );

  assign w_start_div = is_div_op(bus.op);

  // Multiply: {acc_hi, multiplier} shifts right, adding the multiplicand when the LSB is set.
  assign w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Divide: {remainder, dividend} shifts left; quotient bits enter at the LSB.
  assign w_shift = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_diff  = w_shift - {1'b0, r_opnd};

  assign w_step = !is_div_op(r_op) ? {w_sum, r_acc[DATA_W-1:1]} :
                  w_diff[DATA_W]   ? {w_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0} :
                                     {w_diff[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_op            <= MD_MULT;
      r_opnd          <= '0;
      r_acc           <= '0;
      r_neg_res       <= 1'b0;
      r_neg_rem       <= 1'b0;
      r_a_raw         <= '0;
      r_b_zero        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op            <= bus.op;
            r_neg_res       <= w_neg_res;
            r_neg_rem       <= w_neg_rem;
            r_a_raw         <= bus.operand_a;
            r_b_zero        <= (bus.operand_b == '0);
            r_opnd          <= w_start_div ? w_b_mag : w_a_mag;
            r_acc           <= {{DATA_W{1'b0}}, (w_start_div ? w_a_mag : w_b_mag)};
            r_cnt           <= '0;
            bus.busy        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            r_state         <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MD_ITER - 1)) r_state <= FINISH;
        end
        FINISH: begin
          if (is_div_op(r_op) && r_b_zero) begin
            bus.hi          <= r_a_raw;
            bus.lo          <= '1;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.hi <= w_hi;
            bus.lo <= w_lo;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
